// File: rtl/piso_serializer.sv
// Parallel-in serial-out stage: one word per valid/ready handshake, one bit per clock.
// Define PISO_PARITY_EN to append an even-parity bit after the data bits.
module piso_serializer #(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             serial_out,
    output logic             shift_out,
    output logic             busy,
    output logic             done
);

`ifdef PISO_PARITY_EN
    localparam int N = WIDTH + 1;
`else
    localparam int N = WIDTH;
`endif
    localparam int CW = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  sreg_q, sreg_d;
    logic          serial_q, serial_d;
    logic          shift_q, shift_d;

    logic [N-1:0]  load_word;
    logic [N-1:0]  src;
    logic [N-1:0]  adv;
    logic          head;

    // Parity rides at the tail of the shift register so it leaves last.
    always_comb begin
`ifdef PISO_PARITY_EN
        load_word = (MSB_FIRST != 0) ? {data_in, ^data_in}
                                     : {^data_in, data_in};
`else
        load_word = data_in;
`endif
    end

    always_comb begin
        src  = (state_q == IDLE) ? load_word : sreg_q;
        head = (MSB_FIRST != 0) ? src[N-1] : src[0];
        adv  = (MSB_FIRST != 0) ? {src[N-2:0], 1'b0}
                                : {1'b0, src[N-1:1]};
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sreg_d   = sreg_q;
        serial_d = 1'b0;
        shift_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (data_valid) begin
                    state_d  = SHIFT;
                    cnt_d    = '0;
                    sreg_d   = adv;
                    serial_d = head;
                    shift_d  = 1'b1;
                end
            end
            SHIFT: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end else begin
                    sreg_d   = adv;
                    serial_d = head;
                    shift_d  = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sreg_q   <= '0;
            serial_q <= 1'b0;
            shift_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sreg_q   <= sreg_d;
            serial_q <= serial_d;
            shift_q  <= shift_d;
        end
    end

    assign data_ready = (state_q == IDLE);
    assign busy       = (state_q == SHIFT) || (state_q == DONE);
    assign done       = (state_q == DONE);
    assign serial_out = serial_q;
    assign shift_out  = shift_q;

endmodule
